io_mem_stream_reader: RTL

Upstream request engine for the IO DMem controller. On a start command, it reads a contiguous block of DMem words through the accelerator memory request/response interface. It buffers the returned words in a small FIFO and presents them as a valid/ready stream with a last marker. It sits between the conv2D accelerator datapath (stream consumer) and the IO DMem controller (memory side), and never issues writes.

---
 rtl/io_mem_stream_reader.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/io_mem_stream_reader.sv
// io_mem_stream_reader: reads a contiguous block of DMem words, one request at a time, and
// streams the returned words out of a small registered FIFO with a last marker.
module io_mem_stream_reader #(
  parameter int unsigned AWIDTH     = 32,
  parameter int unsigned DWIDTH     = 32,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [AWIDTH-1:0]    start_addr,
  input  logic [LEN_WIDTH-1:0] start_len,
  output logic                 busy,
  output logic                 done,
  output logic [AWIDTH-1:0]    mem_req_addr,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic [DWIDTH-1:0]    mem_req_data,
  output logic                 mem_req_write,
  input  logic [DWIDTH-1:0]    mem_resp_data,
  input  logic                 mem_resp_valid,
  output logic                 mem_resp_ready,
  output logic [DWIDTH-1:0]    out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StReq, StResp, StDrain, StDone} state_e;

  state_e               state_q, state_d;
  logic [AWIDTH-1:0]    addr_q, addr_d;
  logic [LEN_WIDTH-1:0] req_left_q, req_left_d;
  logic [LEN_WIDTH-1:0] out_left_q, out_left_d;

  logic [DWIDTH-1:0]    fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     count_q;

  logic start_fire, req_fire, resp_fire, out_fire;

  // Outputs are decoded from state and FIFO occupancy only (no input-to-output paths).
  always_comb begin
    start_ready    = (state_q == StIdle);
    busy           = (state_q != StIdle);
    done           = (state_q == StDone);
    mem_req_addr   = addr_q;
    mem_req_valid  = (state_q == StReq) && (count_q < FULL);
    mem_req_data   = '0;
    mem_req_write  = 1'b0;
    mem_resp_ready = (state_q == StResp);
    out_valid      = (count_q != '0);
    out_data       = fifo_mem[rd_ptr_q];
    out_last       = out_valid && (out_left_q == LEN_WIDTH'(1));
    start_fire     = start_valid && start_ready;
    req_fire       = mem_req_valid && mem_req_ready;
    resp_fire      = mem_resp_valid && mem_resp_ready;
    out_fire       = out_valid && out_ready;
  end

  // Next-state logic for the request engine and the word counters.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    req_left_d = req_left_q;
    out_left_d = out_left_q;
    if (out_fire) begin
      out_left_d = out_left_q - LEN_WIDTH'(1);
    end
    unique case (state_q)
      StIdle: begin
        if (start_fire) begin
          addr_d     = start_addr;
          req_left_d = start_len;
          out_left_d = start_len;
          state_d    = (start_len == '0) ? StDone : StReq;
        end
      end
      StReq: begin
        if (req_fire) begin
          addr_d     = addr_q + AWIDTH'(1);
          req_left_d = req_left_q - LEN_WIDTH'(1);
          state_d    = StResp;
        end
      end
      StResp: begin
        if (resp_fire) begin
          state_d = (req_left_q != '0) ? StReq : StDrain;
        end
      end
      // Look at the post-pop count so done follows the final handshake by one cycle.
      StDrain: begin
        if (out_left_d == '0) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Engine state and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      req_left_q <= '0;
      out_left_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      req_left_q <= req_left_d;
      out_left_q <= out_left_d;
    end
  end

  // FIFO pointers and occupancy; push and pop together leave the count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (resp_fire) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (out_fire) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (resp_fire && !out_fire) begin
        count_q <= count_q + CNT_W'(1);
      end else if (!resp_fire && out_fire) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  // FIFO storage; contents are don't-care while the count is zero, so no reset is needed.
  always_ff @(posedge clk) begin
    if (resp_fire) begin
      fifo_mem[wr_ptr_q] <= mem_resp_data;
    end
  end

endmodule
